// File: rtl/bram_alu_pkg.sv
// Shared definitions for the BRAM ALU engine: op codes, FSM state encoding
// and a helper that classifies which ops produce a response.
package bram_alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_IDLE     = 3'b000;
  localparam logic [OP_W-1:0] OP_READ     = 3'b001;
  localparam logic [OP_W-1:0] OP_WRITE    = 3'b010;
  localparam logic [OP_W-1:0] OP_READ_ADD = 3'b011;
  localparam logic [OP_W-1:0] OP_READ_SUB = 3'b100;
  localparam logic [OP_W-1:0] OP_ACC      = 3'b101;
  localparam logic [OP_W-1:0] OP_CLEAR    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RMW   = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  // Ops that read the RAM and return a response two cycles after accept.
  function automatic logic op_responds(input logic [OP_W-1:0] op);
    return (op == OP_READ) || (op == OP_READ_ADD) ||
           (op == OP_READ_SUB) || (op == OP_ACC);
  endfunction

endpackage

// File: rtl/bram_alu_engine_sp.sv
// Single-port synchronous RAM with registered read data.
// Ports: clk; we (write enable); addr; wdata; rdata (registered read of addr).
// Contents are not reset. Writes outside RAM_DEPTH must be blocked by the caller.
module bram_sp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RAM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // Read-before-write port; the engine never uses the read data of a write cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bram_alu_engine.sv
// BRAM ALU engine: request/response front end over one single-port RAM with
// read, write, read-add, read-sub, accumulate (RMW) and whole-array clear.
// Ports: clk, rstn (async active-low); req_valid/req_ready/op/addr/din request;
// rsp_valid pulse with dout/cout/rsp_err held until the next response.
module bram_alu_engine
  import bram_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RAM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_W-1:0]       op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  cout,
  output logic                  rsp_err
);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  p1_valid_q;
  logic [OP_W-1:0]       p1_op_q;
  logic                  p1_err_q;
  logic [ADDR_WIDTH-1:0] p1_addr_q;
  logic [DATA_WIDTH-1:0] p1_din_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  accept_c;
  logic                  addr_ok_c;
  logic                  clear_last_c;
  logic [DATA_WIDTH:0]   sum_c;
  logic                  ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_WIDTH-1:0] ram_wdata_c;

  // Ready is decoded from the state register and forced low while in reset.
  assign req_ready    = rstn && (state_q == S_IDLE);
  assign accept_c     = req_valid && req_ready;
  assign addr_ok_c    = 32'(addr) < RAM_DEPTH;
  assign clear_last_c = (state_q == S_CLEAR) && (cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1));
  assign sum_c        = {1'b0, ram_rdata} + {1'b0, p1_din_q};

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c && (op == OP_ACC)) begin
          state_d = S_RMW;
        end else if (accept_c && (op == OP_CLEAR)) begin
          state_d = S_CLEAR;
        end
      end
      S_RMW:   state_d = S_IDLE;
      S_CLEAR: if (clear_last_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM port mux: request path, RMW write-back or clear sweep.
  always_comb begin
    ram_we_c    = 1'b0;
    ram_addr_c  = addr;
    ram_wdata_c = din;
    case (state_q)
      S_IDLE: ram_we_c = accept_c && (op == OP_WRITE) && addr_ok_c;
      S_RMW: begin
        ram_we_c    = !p1_err_q;
        ram_addr_c  = p1_addr_q;
        ram_wdata_c = sum_c[DATA_WIDTH-1:0];
      end
      S_CLEAR: begin
        ram_we_c    = 1'b1;
        ram_addr_c  = cnt_q;
        ram_wdata_c = '0;
      end
      default: ram_we_c = 1'b0;
    endcase
  end

  bram_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_c),
    .addr (ram_addr_c),
    .wdata(ram_wdata_c),
    .rdata(ram_rdata)
  );

  // Clear sweep counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (accept_c && (op == OP_CLEAR)) begin
      cnt_q <= '0;
    end else if (state_q == S_CLEAR) begin
      cnt_q <= clear_last_c ? '0 : cnt_q + ADDR_WIDTH'(1);
    end
  end

  // First response stage: shadows the request alongside the registered RAM read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p1_valid_q <= 1'b0;
      p1_op_q    <= OP_IDLE;
      p1_err_q   <= 1'b0;
      p1_addr_q  <= '0;
      p1_din_q   <= '0;
    end else begin
      p1_valid_q <= accept_c && op_responds(op);
      if (accept_c) begin
        p1_op_q   <= op;
        p1_err_q  <= !addr_ok_c;
        p1_addr_q <= addr;
        p1_din_q  <= din;
      end
    end
  end

  // Second response stage: ALU result or clear completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      dout      <= '0;
      cout      <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (p1_valid_q) begin
        rsp_valid <= 1'b1;
        rsp_err   <= p1_err_q;
        if (p1_err_q) begin
          dout <= '0;
          cout <= 1'b0;
        end else begin
          case (p1_op_q)
            OP_READ: begin
              dout <= ram_rdata;
              cout <= 1'b0;
            end
            OP_READ_SUB: begin
              dout <= ram_rdata - p1_din_q;
              cout <= ram_rdata < p1_din_q;
            end
            default: {cout, dout} <= sum_c;
          endcase
        end
      end else if (clear_last_c) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        dout      <= '0;
        cout      <= 1'b0;
      end
    end
  end

endmodule
